// File: rtl/hrm_host_pkg.sv
// Shared constants and state encodings for the HRM host bridge.
package hrm_host_pkg;

   localparam logic [7:0] CMD_INBOX  = 8'h49;
   localparam logic [7:0] CMD_DUMP   = 8'h44;
   localparam logic [7:0] CMD_STEP   = 8'h53;
   localparam logic [7:0] CMD_BREAK  = 8'h42;
   localparam logic [7:0] CMD_GO     = 8'h47;
   localparam logic [7:0] RSP_DUMP   = 8'h44;
   localparam logic [7:0] RSP_OUTBOX = 8'h4F;

   typedef enum logic [1:0] {
      R_IDLE    = 2'd0,
      R_IN_ARG  = 2'd1,
      R_DMP_ARG = 2'd2
   } rx_state_e;

   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_HDR  = 2'd1,
      T_B1   = 2'd2,
      T_B2   = 2'd3
   } tx_state_e;

   function automatic logic [7:0] dump_status(input logic valid);
      return {7'b0000000, valid};
   endfunction

endpackage

// File: rtl/hrm_host_tx.sv
// Frame sequencer: sends a header plus one or two payload bytes over a valid/ready link.
module hrm_host_tx
   import hrm_host_pkg::*;
(
   input  logic       clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic [7:0] i_hdr,
   input  logic [7:0] i_b1,
   input  logic [7:0] i_b2,
   input  logic       i_two_bytes,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       o_done
);

   tx_state_e  state_q, state_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic [7:0] b1_q, b1_d;
   logic [7:0] b2_q, b2_d;
   logic       two_q, two_d;

   // next-state: payload is captured at start so callers may change their sources afterwards
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = valid_q;
      b1_d    = b1_q;
      b2_d    = b2_q;
      two_d   = two_q;
      o_done  = 1'b0;
      case (state_q)
         T_IDLE: begin
            if (i_start) begin
               state_d = T_HDR;
               data_d  = i_hdr;
               valid_d = 1'b1;
               b1_d    = i_b1;
               b2_d    = i_b2;
               two_d   = i_two_bytes;
            end else begin
               valid_d = 1'b0;
            end
         end
         T_HDR: begin
            if (tx_ready) begin
               state_d = T_B1;
               data_d  = b1_q;
            end else begin
               state_d = T_HDR;
            end
         end
         T_B1: begin
            if (tx_ready && two_q) begin
               state_d = T_B2;
               data_d  = b2_q;
            end else if (tx_ready) begin
               state_d = T_IDLE;
               valid_d = 1'b0;
               o_done  = 1'b1;
            end else begin
               state_d = T_B1;
            end
         end
         T_B2: begin
            if (tx_ready) begin
               state_d = T_IDLE;
               valid_d = 1'b0;
               o_done  = 1'b1;
            end else begin
               state_d = T_B2;
            end
         end
         default: begin
            state_d = T_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // state and frame registers
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q <= T_IDLE;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         b1_q    <= 8'h00;
         b2_q    <= 8'h00;
         two_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         b1_q    <= b1_d;
         b2_q    <= b2_d;
         two_q   <= two_d;
      end
   end

   assign tx_data  = data_q;
   assign tx_valid = valid_q;

endmodule

// File: rtl/hrm_host_bridge.sv
// Host bridge for the HRM CPU: parses host commands, feeds the INBOX, and frames
// dump snapshots and OUTBOX bytes back to the host.
module hrm_host_bridge
   import hrm_host_pkg::*;
#(
   parameter bit DRAIN_EN = 1'b1
) (
   input  logic       clk,
   input  logic       i_rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [7:0] cpu_in_data,
   output logic       cpu_in_wr,
   input  logic       cpu_in_full,
   input  logic [7:0] cpu_out_data,
   input  logic       cpu_out_empty,
   output logic       cpu_out_rd,
   output logic [2:0] cpu_dmp_chip_select,
   output logic [4:0] cpu_dmp_fifo_pos,
   input  logic [7:0] cpu_dmp_data,
   input  logic       cpu_dmp_valid,
   output logic       cpu_debug,
   output logic       cpu_nxtInstr,
   output logic       o_drop
);

   rx_state_e  rx_state_q, rx_state_d;
   logic [7:0] in_data_q, in_data_d;
   logic       in_wr_q, in_wr_d;
   logic       nxt_q, nxt_d;
   logic       debug_q, debug_d;
   logic       drop_q, drop_d;
   logic [2:0] sel_q, sel_d;
   logic [4:0] pos_q, pos_d;
   logic       snap_q, snap_d;
   logic       pend_q, pend_d;
   logic       snap_valid_q, snap_valid_d;
   logic [7:0] snap_data_q, snap_data_d;
   logic       out_rd_q, out_rd_d;
   logic       busy_q, busy_d;

   logic       start_dump;
   logic       tx_start;
   logic       tx_done;
   logic [7:0] frame_hdr;
   logic [7:0] frame_b1;

   // command parser
   always_comb begin
      rx_state_d = rx_state_q;
      in_data_d  = in_data_q;
      in_wr_d    = 1'b0;
      nxt_d      = 1'b0;
      debug_d    = debug_q;
      drop_d     = 1'b0;
      sel_d      = sel_q;
      pos_d      = pos_q;
      snap_d     = 1'b0;
      if (rx_valid) begin
         case (rx_state_q)
            R_IDLE: begin
               case (rx_data)
                  CMD_INBOX: rx_state_d = R_IN_ARG;
                  CMD_DUMP:  rx_state_d = R_DMP_ARG;
                  CMD_STEP:  nxt_d      = 1'b1;
                  CMD_BREAK: debug_d    = 1'b1;
                  CMD_GO:    debug_d    = 1'b0;
                  default:   rx_state_d = R_IDLE;
               endcase
            end
            R_IN_ARG: begin
               rx_state_d = R_IDLE;
               if (!cpu_in_full) begin
                  in_wr_d   = 1'b1;
                  in_data_d = rx_data;
               end else begin
                  drop_d = 1'b1;
               end
            end
            R_DMP_ARG: begin
               rx_state_d = R_IDLE;
               // one request deep: a snapshot still on its way to pending also counts
               if (pend_q || snap_q) begin
                  drop_d = 1'b1;
               end else begin
                  sel_d  = rx_data[2:0];
                  pos_d  = rx_data[7:3];
                  snap_d = 1'b1;
               end
            end
            default: rx_state_d = R_IDLE;
         endcase
      end else begin
         rx_state_d = rx_state_q;
      end
   end

   // dump snapshot, OUTBOX pop and frame arbitration
   always_comb begin
      snap_valid_d = snap_valid_q;
      snap_data_d  = snap_data_q;
      start_dump   = !busy_q && pend_q && !out_rd_q;
      tx_start     = start_dump || out_rd_q;
      frame_hdr    = start_dump ? RSP_DUMP : RSP_OUTBOX;
      frame_b1     = start_dump ? dump_status(snap_valid_q) : cpu_out_data;
      out_rd_d     = DRAIN_EN && !busy_q && !out_rd_q && !pend_q && !cpu_out_empty;
      if (snap_q) begin
         snap_valid_d = cpu_dmp_valid;
         snap_data_d  = cpu_dmp_data;
         pend_d       = 1'b1;
      end else if (start_dump) begin
         pend_d = 1'b0;
      end else begin
         pend_d = pend_q;
      end
      if (tx_start) begin
         busy_d = 1'b1;
      end else if (tx_done) begin
         busy_d = 1'b0;
      end else begin
         busy_d = busy_q;
      end
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (i_rst) begin
         rx_state_q   <= R_IDLE;
         in_data_q    <= 8'h00;
         in_wr_q      <= 1'b0;
         nxt_q        <= 1'b0;
         debug_q      <= 1'b0;
         drop_q       <= 1'b0;
         sel_q        <= 3'd0;
         pos_q        <= 5'd0;
         snap_q       <= 1'b0;
         pend_q       <= 1'b0;
         snap_valid_q <= 1'b0;
         snap_data_q  <= 8'h00;
         out_rd_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         rx_state_q   <= rx_state_d;
         in_data_q    <= in_data_d;
         in_wr_q      <= in_wr_d;
         nxt_q        <= nxt_d;
         debug_q      <= debug_d;
         drop_q       <= drop_d;
         sel_q        <= sel_d;
         pos_q        <= pos_d;
         snap_q       <= snap_d;
         pend_q       <= pend_d;
         snap_valid_q <= snap_valid_d;
         snap_data_q  <= snap_data_d;
         out_rd_q     <= out_rd_d;
         busy_q       <= busy_d;
      end
   end

   hrm_host_tx u_tx (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_start     (tx_start),
      .i_hdr       (frame_hdr),
      .i_b1        (frame_b1),
      .i_b2        (snap_data_q),
      .i_two_bytes (start_dump),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .o_done      (tx_done)
   );

   assign cpu_in_data         = in_data_q;
   assign cpu_in_wr           = in_wr_q;
   assign cpu_out_rd          = out_rd_q;
   assign cpu_dmp_chip_select = sel_q;
   assign cpu_dmp_fifo_pos    = pos_q;
   assign cpu_debug           = debug_q;
   assign cpu_nxtInstr        = nxt_q;
   assign o_drop              = drop_q;

endmodule

// File: tb/tb_hrm_host_bridge.sv
// Scoreboard bench for hrm_host_bridge; a second instance with DRAIN_EN=0 shares the inputs.
module tb_hrm_host_bridge;

   logic       clk = 1'b0;
   logic       i_rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] cpu_in_data;
   logic       cpu_in_wr;
   logic       cpu_in_full;
   logic [7:0] cpu_out_data  = 8'h00;
   logic       cpu_out_empty = 1'b1;
   logic       cpu_out_rd;
   logic [2:0] sel;
   logic [4:0] pos;
   logic [7:0] dmp_data;
   logic       dmp_valid;
   logic       cpu_debug;
   logic       cpu_nxt;
   logic       o_drop;

   logic [7:0] tx_data_z, in_data_z;
   logic       tx_valid_z, in_wr_z, out_rd_z, debug_z, nxt_z, drop_z;
   logic [2:0] sel_z;
   logic [4:0] pos_z;

   int n_vec = 0, n_err = 0;
   int n_xfer = 0, n_inwr = 0, n_rd = 0, n_rd_bad = 0, n_rd_z = 0, n_drop = 0, n_nxt = 0;
   logic [7:0] exp_tx[$];
   logic [7:0] exp_in[$];
   logic [7:0] ob_q[$];
   logic       hold_q = 1'b0;
   logic [7:0] hold_data = 8'h00;

   always #5 clk = ~clk;

   hrm_host_bridge #(.DRAIN_EN(1'b1)) dut (
      .clk(clk), .i_rst(i_rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .cpu_in_data(cpu_in_data), .cpu_in_wr(cpu_in_wr), .cpu_in_full(cpu_in_full),
      .cpu_out_data(cpu_out_data), .cpu_out_empty(cpu_out_empty), .cpu_out_rd(cpu_out_rd),
      .cpu_dmp_chip_select(sel), .cpu_dmp_fifo_pos(pos),
      .cpu_dmp_data(dmp_data), .cpu_dmp_valid(dmp_valid),
      .cpu_debug(cpu_debug), .cpu_nxtInstr(cpu_nxt), .o_drop(o_drop)
   );

   hrm_host_bridge #(.DRAIN_EN(1'b0)) dut_nodrain (
      .clk(clk), .i_rst(i_rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data_z), .tx_valid(tx_valid_z), .tx_ready(1'b1),
      .cpu_in_data(in_data_z), .cpu_in_wr(in_wr_z), .cpu_in_full(cpu_in_full),
      .cpu_out_data(cpu_out_data), .cpu_out_empty(cpu_out_empty), .cpu_out_rd(out_rd_z),
      .cpu_dmp_chip_select(sel_z), .cpu_dmp_fifo_pos(pos_z),
      .cpu_dmp_data(dmp_data), .cpu_dmp_valid(dmp_valid),
      .cpu_debug(debug_z), .cpu_nxtInstr(nxt_z), .o_drop(drop_z)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 50 && !tx_valid; i++) tick(1);
      chk("tx_valid_wait", {31'd0, tx_valid}, 32'd1);
   endtask

   task automatic push_tx(input logic [7:0] a, input logic [7:0] b);
      exp_tx.push_back(a);
      exp_tx.push_back(b);
   endtask

   // OUTBOX model: pop on the edge that ends a cpu_out_rd cycle, update head just after
   always @(posedge clk) begin
      if (cpu_out_rd && ob_q.size() > 0) void'(ob_q.pop_front());
      #1;
      cpu_out_empty = (ob_q.size() == 0);
      cpu_out_data  = (ob_q.size() == 0) ? 8'h00 : ob_q[0];
   end

   // monitor: compare transfers against the scoreboard and count pulses
   always @(negedge clk) begin
      if (tx_valid && tx_ready) begin
         n_xfer++;
         if (exp_tx.size() == 0) chk("tx_extra", {24'd0, tx_data}, 32'hFFFF_FFFF);
         else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
      end
      if (hold_q && tx_valid) chk("tx_hold", {24'd0, tx_data}, {24'd0, hold_data});
      hold_q    = tx_valid && !tx_ready;
      hold_data = tx_data;
      if (cpu_in_wr) begin
         n_inwr++;
         if (exp_in.size() == 0) chk("in_extra", {24'd0, cpu_in_data}, 32'hFFFF_FFFF);
         else chk("in_data", {24'd0, cpu_in_data}, {24'd0, exp_in.pop_front()});
      end
      if (cpu_out_rd) begin
         n_rd++;
         if (cpu_out_empty) n_rd_bad++;
      end
      if (out_rd_z) n_rd_z++;
      if (o_drop) n_drop++;
      if (cpu_nxt) n_nxt++;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int drop0, in0;
      i_rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
      cpu_in_full = 1'b0; dmp_valid = 1'b0; dmp_data = 8'h00;
      tick(3);
      chk("rst_tx", {23'd0, tx_valid, tx_data}, 32'd0);
      chk("rst_ctl", {27'd0, cpu_in_wr, cpu_out_rd, cpu_nxt, o_drop, cpu_debug}, 32'd0);
      chk("rst_bus", {16'd0, sel, pos, cpu_in_data}, 32'd0);
      i_rst = 1'b0;
      tick(1);

      // INBOX write
      send(8'h49); exp_in.push_back(8'h2A); send(8'h2A);
      chk("in_wr_lat", {31'd0, cpu_in_wr}, 32'd1);
      tick(3);
      chk("in_wr_cnt", n_inwr, 1);
      chk("in_no_tx", n_xfer, 0);

      // INBOX full, then a normal write
      cpu_in_full = 1'b1;
      send(8'h49); send(8'h07); tick(2);
      chk("full_drop", n_drop, 1);
      chk("full_no_wr", n_inwr, 1);
      cpu_in_full = 1'b0;
      send(8'h49); exp_in.push_back(8'h33); send(8'h33);
      chk("in_wr_lat2", {31'd0, cpu_in_wr}, 32'd1);
      tick(2);
      chk("in_wr_cnt2", n_inwr, 2);

      // dump with backpressure before every byte
      dmp_valid = 1'b1; dmp_data = 8'h5C; tx_ready = 1'b0;
      push_tx(8'h44, 8'h01); exp_tx.push_back(8'h5C);
      send(8'h44); send(8'h1A);
      chk("dmp_sel", {29'd0, sel}, 32'd2);
      chk("dmp_pos", {27'd0, pos}, 32'd3);
      chk("dmp_early", {31'd0, tx_valid}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         wait_valid();
         tick(5);
         tx_ready = 1'b1;
         tick(1);
         tx_ready = 1'b0;
      end
      tick(3);
      chk("dmp_frame", exp_tx.size(), 0);

      // OUTBOX drain
      tx_ready = 1'b1;
      push_tx(8'h4F, 8'h80); ob_q.push_back(8'h80);
      tick(10);
      chk("ob_rd_cnt", n_rd, 1);
      chk("ob_frame", exp_tx.size(), 0);
      chk("ob_nodrain", n_rd_z, 0);

      // dump priority over OUTBOX, one-deep pending, third request dropped
      tx_ready = 1'b0; dmp_valid = 1'b0; dmp_data = 8'h11;
      push_tx(8'h44, 8'h00); exp_tx.push_back(8'h11);
      send(8'h44); send(8'h00); tick(3);
      chk("pri_busy", {31'd0, tx_valid}, 32'd1);
      dmp_valid = 1'b1; dmp_data = 8'h22;
      push_tx(8'h44, 8'h01); exp_tx.push_back(8'h22);
      send(8'h44); send(8'h05);
      ob_q.push_back(8'h99); push_tx(8'h4F, 8'h99);
      tick(3);
      drop0 = n_drop;
      send(8'h44); send(8'h07); tick(2);
      chk("pend_drop", n_drop, drop0 + 1);
      chk("pend_sel", {29'd0, sel}, 32'd5);
      chk("pend_pos", {27'd0, pos}, 32'd0);
      chk("pri_no_rd", n_rd, 1);
      tx_ready = 1'b1;
      tick(25);
      chk("pri_order", exp_tx.size(), 0);
      chk("pri_rd", n_rd, 2);

      // debug / step
      send(8'h42);
      chk("dbg_set", {31'd0, cpu_debug}, 32'd1);
      send(8'h53);
      chk("step_pulse", {31'd0, cpu_nxt}, 32'd1);
      tick(3);
      chk("step_cnt", n_nxt, 1);

      // reset mid-frame with the parser left waiting for an INBOX argument
      tx_ready = 1'b0;
      send(8'h44); send(8'h00);
      wait_valid();
      send(8'h49);
      i_rst = 1'b1;
      tick(1);
      chk("rst_mid_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_mid_dbg", {31'd0, cpu_debug}, 32'd0);
      i_rst = 1'b0; tx_ready = 1'b1;
      in0 = n_inwr;
      send(8'h53);
      chk("rst_parse_step", {31'd0, cpu_nxt}, 32'd1);
      tick(3);
      chk("rst_no_inwr", n_inwr, in0);
      chk("rst_step_cnt", n_nxt, 2);
      send(8'h42); send(8'h47);
      chk("dbg_clr", {31'd0, cpu_debug}, 32'd0);
      tick(5);

      chk("in_left", exp_in.size(), 0);
      chk("tx_left", exp_tx.size(), 0);
      chk("rd_when_empty", n_rd_bad, 0);
      chk("nodrain_rd", n_rd_z, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
